// File: rtl/cpu_ctrl.sv
// Multi-cycle control unit for a 16-bit-instruction datapath: drives the fetch/decode/execute/writeback
// sequence, the program counter and the register-file/ALU control strobes.
module cpu_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] instr,
    input  logic [7:0]  RD1,
    output logic [7:0]  PC,
    output logic [3:0]  RA1,
    output logic [3:0]  RA2,
    output logic [3:0]  WA,
    output logic        write_enable,
    output logic [2:0]  ALUControl,
    output logic        imm_sel,
    output logic [7:0]  imm,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_BEQZ = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;
    logic [7:0]  r_pc;
    logic [7:0]  w_next_pc;
    logic        r_rd1_zero;
    logic [3:0]  w_opcode;
    logic [7:0]  w_imm;
    logic        w_writes_rf;

    assign w_opcode = r_ir[15:12];
    assign w_imm    = r_ir[7:0];

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
        if (RST) begin
            r_state    <= S_IDLE;
            r_ir       <= 16'h0000;
            r_pc       <= 8'h00;
            r_rd1_zero <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= instr;
            end
            // Branch operand is captured in EXEC so WB resolves the target from a registered flag.
            if (r_state == S_EXEC) begin
                r_rd1_zero <= (RD1 == 8'h00);
            end
            if (r_state == S_WB) begin
                r_pc <= w_next_pc;
            end
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves the target unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC:   w_next_state = (w_opcode == OP_HALT) ? S_HALT : S_WB;
            S_WB:     w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_next_pc = r_pc + 8'd1;
        case (w_opcode)
            OP_JMP:  w_next_pc = w_imm;
            OP_BEQZ: if (r_rd1_zero) w_next_pc = w_imm;
            default: w_next_pc = r_pc + 8'd1;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (w_opcode)
            OP_SUB:  ALUControl = 3'b001;
            OP_AND:  ALUControl = 3'b010;
            OP_OR:   ALUControl = 3'b011;
            OP_XOR:  ALUControl = 3'b100;
            OP_LDI:  ALUControl = 3'b101;
            default: ALUControl = 3'b000;
        endcase
    end

    assign w_writes_rf = (w_opcode >= OP_ADD) && (w_opcode <= OP_LDI);

    // Reset gates the strobe combinationally so a WB cycle under reset never commits.
    assign write_enable = (r_state == S_WB) && w_writes_rf && !RST;
    assign imm_sel      = (w_opcode == OP_LDI);
    assign imm          = w_imm;
    assign RA1          = r_ir[7:4];
    assign RA2          = r_ir[3:0];
    assign WA           = r_ir[11:8];
    assign PC           = r_pc;
    assign busy         = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                          (r_state == S_EXEC)  || (r_state == S_WB);
    assign halted       = (r_state == S_HALT);

endmodule
